int_mac_pipe: RTL and testbench

- Parametrised, fully pipelined integer multiply-accumulate for the execute/arithmetic cluster; successor to the single-in-flight MAC.
- Computes A*B+C, or A*B plus an internal running accumulator, with one operation accepted per cycle under valid/ready backpressure.
- Carries a per-result overflow flag.
- Sits between issue and writeback, like the other arithmetic units.

---
 rtl/int_mac_pipe.sv | 128 ++++++++++++
 tb/tb_int_mac_pipe.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/int_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : int_mac_pipe
// Description : Fully pipelined integer multiply-accumulate (A*B+C or A*B+ACC)
//               with valid/ready flow control and per-result overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module int_mac_pipe #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3,
    parameter int SIGNED  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_acc,
    input  logic             acc_clear,
    input  logic [WIDTH-1:0] a_data,
    input  logic [WIDTH-1:0] b_data,
    input  logic [WIDTH-1:0] c_data,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result_data,
    output logic             result_ovf
);

    localparam int c_PROD_W = 2 * WIDTH;

    logic [c_PROD_W-1:0] w_a_ext;
    logic [c_PROD_W-1:0] w_b_ext;
    logic [c_PROD_W-1:0] w_prod;
    logic [c_PROD_W:0]   w_prod_ext;
    logic [c_PROD_W:0]   w_add_ext;
    logic [c_PROD_W:0]   w_sum;
    logic [WIDTH-1:0]    w_addend;
    logic                w_ovf;
    logic                w_accept;

    logic [WIDTH-1:0]    r_acc;
    logic [WIDTH-1:0]    w_acc_d;

    logic [LATENCY-1:0]  r_valid;
    logic [LATENCY-1:0]  r_ovf;
    logic [WIDTH-1:0]    r_data [LATENCY];
    logic [LATENCY-1:0]  w_valid_d;
    logic [LATENCY-1:0]  w_ovf_d;
    logic [WIDTH-1:0]    w_data_d [LATENCY];
    logic [LATENCY-1:0]  w_adv;

    // A stage may move when any stage from it to the output is empty, or the
    // consumer is taking the result; this is the unrolled form of the chain.
    generate
        for (genvar k = 0; k < LATENCY; k++) begin : g_adv
            assign w_adv[k] = result_ready | ~(&r_valid[LATENCY-1:k]);
        end
    endgenerate

    assign in_ready = w_adv[0];
    assign w_accept = in_valid & w_adv[0];

    always_comb begin
        w_addend = (op_acc && !acc_clear) ? r_acc : c_data;
        if (SIGNED != 0) begin
            w_a_ext   = {{WIDTH{a_data[WIDTH-1]}}, a_data};
            w_b_ext   = {{WIDTH{b_data[WIDTH-1]}}, b_data};
            w_add_ext = {{(WIDTH+1){w_addend[WIDTH-1]}}, w_addend};
        end else begin
            w_a_ext   = {{WIDTH{1'b0}}, a_data};
            w_b_ext   = {{WIDTH{1'b0}}, b_data};
            w_add_ext = {{(WIDTH+1){1'b0}}, w_addend};
        end
        // Truncated 2W-bit product of extended operands is exact for both modes.
        w_prod     = w_a_ext * w_b_ext;
        w_prod_ext = (SIGNED != 0) ? {w_prod[c_PROD_W-1], w_prod} : {1'b0, w_prod};
        w_sum      = w_prod_ext + w_add_ext;
        if (SIGNED != 0) begin
            w_ovf = !((&w_sum[c_PROD_W:WIDTH-1]) || !(|w_sum[c_PROD_W:WIDTH-1]));
        end else begin
            w_ovf = |w_sum[c_PROD_W:WIDTH];
        end
        w_acc_d = (w_accept && op_acc) ? w_sum[WIDTH-1:0] : r_acc;
    end

    always_comb begin
        w_valid_d = r_valid;
        w_ovf_d   = r_ovf;
        for (int k = 0; k < LATENCY; k++) begin
            w_data_d[k] = r_data[k];
        end
        if (w_adv[0]) begin
            w_valid_d[0] = in_valid;
            w_ovf_d[0]   = w_ovf;
            w_data_d[0]  = w_sum[WIDTH-1:0];
        end
        for (int k = 1; k < LATENCY; k++) begin
            if (w_adv[k]) begin
                w_valid_d[k] = r_valid[k-1];
                w_ovf_d[k]   = r_ovf[k-1];
                w_data_d[k]  = r_data[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= '0;
            r_ovf   <= '0;
            r_acc   <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_valid <= w_valid_d;
            r_ovf   <= w_ovf_d;
            r_acc   <= w_acc_d;
            for (int k = 0; k < LATENCY; k++) begin
                r_data[k] <= w_data_d[k];
            end
        end
    end

    assign result_valid = r_valid[LATENCY-1];
    assign result_data  = r_valid[LATENCY-1] ? r_data[LATENCY-1] : '0;
    assign result_ovf   = r_valid[LATENCY-1] & r_ovf[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_int_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_int_mac_pipe
// Description : Self-checking bench for int_mac_pipe (table vectors + scoreboard).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_int_mac_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready, op_acc = 1'b0, acc_clear = 1'b0;
    logic [31:0] a_data = '0, b_data = '0, c_data = '0;
    logic        result_valid, result_ready = 1'b1, result_ovf;
    logic [31:0] result_data;

    logic        u_in_valid = 1'b0, u_in_ready, u_result_valid, u_result_ovf;
    logic [31:0] u_a = '0, u_b = '0, u_c = '0, u_result_data;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int_mac_pipe #(.WIDTH(32), .LATENCY(3), .SIGNED(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op_acc(op_acc), .acc_clear(acc_clear), .a_data(a_data), .b_data(b_data),
        .c_data(c_data), .result_valid(result_valid), .result_ready(result_ready),
        .result_data(result_data), .result_ovf(result_ovf)
    );

    int_mac_pipe #(.WIDTH(32), .LATENCY(3), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
        .op_acc(1'b0), .acc_clear(1'b0), .a_data(u_a), .b_data(u_b),
        .c_data(u_c), .result_valid(u_result_valid), .result_ready(1'b1),
        .result_data(u_result_data), .result_ovf(u_result_ovf)
    );

    typedef struct {
        logic        acc;
        logic        clr;
        logic [31:0] a, b, c;
        logic [31:0] exp_d;
        logic        exp_o;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        o;
        int          cyc;
        logic        lat;
    } sb_t;

    sb_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every output handshake must match the oldest push.
    always @(negedge clk) begin
        if (rst && result_valid && result_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'd1, 32'd0);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("result_data", result_data, e.d);
                chk("result_ovf", {31'd0, result_ovf}, {31'd0, e.o});
                if (e.lat) chk("latency", cyc - e.cyc, 32'd3);
            end
        end
    end

    task automatic issue(input logic acc, input logic clr, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] c,
                         input logic [31:0] ed, input logic eo, input logic push,
                         input logic lat, output int waits);
        logic rdy;
        int   icyc;
        op_acc = acc; acc_clear = clr; a_data = a; b_data = b; c_data = c;
        in_valid = 1'b1;
        waits = 0;
        forever begin
            @(negedge clk);
            rdy  = in_ready;
            icyc = cyc;
            @(posedge clk);
            if (rdy) break;
            waits++;
            if (waits > 50) begin
                chk("accept_timeout", 32'd1, 32'd0);
                break;
            end
        end
        if (rdy && push) sb.push_back('{ed, eo, icyc, lat});
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    vec_t tbl[$];
    int   w;

    initial begin
        // Latency / plain MAC, accumulate chain, signed boundaries, mixed modes.
        tbl.push_back('{1'b0, 1'b0, 32'd3, 32'd4, 32'd5, 32'd17, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 32'd2, 32'd5, 32'd1, 32'd11, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'd2, 32'd5, 32'd0, 32'd21, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'd2, 32'd5, 32'd0, 32'd31, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'd2, 32'd5, 32'd0, 32'd41, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h7FFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'h7FFFFFFF, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'h7FFFFFFF, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'h80000000, 32'd1, 32'd0, 32'h80000000, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'hFFFFFFFD, 32'd7, 32'd5, 32'hFFFFFFF0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 32'd0, 32'd0, 32'd10, 32'd10, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 32'd1, 32'd1, 32'd100, 32'd101, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 32'd1, 32'd1, 32'd0, 32'd11, 1'b0});

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_result_valid", {31'd0, result_valid}, 32'd0);
        chk("reset_result_data", result_data, 32'd0);
        chk("reset_result_ovf", {31'd0, result_ovf}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            issue(tbl[i].acc, tbl[i].clr, tbl[i].a, tbl[i].b, tbl[i].c,
                  tbl[i].exp_d, tbl[i].exp_o, 1'b1, 1'b1, w);
            chk("back_to_back_ready", w, 32'd0);
        end
        drain();

        // Backpressure: three accepts fill the pipe, then it must stall stably.
        result_ready = 1'b0;
        for (int i = 1; i <= 3; i++) issue(1'b0, 1'b0, i, 32'd1, 32'd0, i, 1'b0, 1'b1, 1'b0, w);
        op_acc = 1'b0; a_data = 32'd4; b_data = 32'd1; c_data = 32'd0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_result_valid", {31'd0, result_valid}, 32'd1);
            chk("stall_result_data", result_data, 32'd1);
            @(posedge clk); #1;
        end
        result_ready = 1'b1;
        for (int i = 4; i <= 6; i++) issue(1'b0, 1'b0, i, 32'd1, 32'd0, i, 1'b0, 1'b1, 1'b0, w);
        drain();

        // Mid-flight reset: in-flight ops and ACC must be discarded.
        issue(1'b1, 1'b1, 32'd3, 32'd3, 32'd7, 32'd0, 1'b0, 1'b0, 1'b0, w);
        issue(1'b1, 1'b0, 32'd3, 32'd3, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, w);
        rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            chk("post_reset_no_result", {31'd0, result_valid}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        issue(1'b1, 1'b0, 32'd1, 32'd1, 32'd0, 32'd1, 1'b0, 1'b1, 1'b1, w);
        drain();

        // Unsigned instance overflow: 0xFFFFFFFF*1 + 1 wraps to 0.
        u_a = 32'hFFFFFFFF; u_b = 32'd1; u_c = 32'd1; u_in_valid = 1'b1;
        @(negedge clk);
        chk("u_in_ready", {31'd0, u_in_ready}, 32'd1);
        @(posedge clk); #1 u_in_valid = 1'b0;
        for (int i = 0; i < 10 && !u_result_valid; i++) @(negedge clk);
        chk("u_result_valid", {31'd0, u_result_valid}, 32'd1);
        chk("u_result_data", u_result_data, 32'd0);
        chk("u_result_ovf", {31'd0, u_result_ovf}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
